// File: rtl/sm_fifo_pkg.sv
// Shared types and sizing for the FIFO read-stream block and its skid buffer.
package sm_fifo_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rd_state_t;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

  // Occupancy after one cycle of push/pop; push+pop leaves it unchanged.
  function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                 input logic push,
                                                 input logic pop);
    logic [OCC_W-1:0] res;
    res = occ;
    if (push && !pop) res = occ + OCC_W'(1);
    if (!push && pop) res = occ - OCC_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/sm_skid_buf2.sv
// Two-entry skid buffer: head entry drives the stream output, second entry absorbs
// the word popped while the consumer stalls.
module sm_skid_buf2
  import sm_fifo_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic [DW-1:0]    head
);

  logic [DW-1:0]    e1;
  logic [OCC_W-1:0] occ_nxt;

  always_comb begin
    occ_nxt = clear ? '0 : occ_next(occ, push, pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ   <= '0;
      valid <= 1'b0;
      head  <= '0;
      e1    <= '0;
    end else begin
      occ   <= occ_nxt;
      valid <= (occ_nxt != '0);
      // Data entries are left as-is on clear; valid gates them.
      if (!clear) begin
        if (push && !pop) begin
          if (occ == '0) head <= din;
          else           e1   <= din;
        end else if (!push && pop) begin
          head <= e1;
        end else if (push && pop) begin
          if (occ == OCC_W'(1)) begin
            head <= din;
          end else begin
            head <= e1;
            e1   <= din;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sm_fifo_rd_stream.sv
// Drains a show-ahead synchronous FIFO into a registered valid/ready stream,
// with a flush mode that discards buffered words and empties the FIFO.
module sm_fifo_rd_stream
  import sm_fifo_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd_en,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  input  logic          flush,
  output logic          flush_busy,
  output logic          flush_done,
  output logic [CW-1:0] rd_count
);

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;
  logic             clear;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Pop decision uses registered occupancy only, so m_ready never reaches fifo_rd_en.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    done_nxt   = 1'b0;
    if (rstn) begin
      unique case (state)
        ST_RUN: begin
          pop = m_valid && m_ready;
          if (flush) begin
            state_nxt = ST_FLUSH;
            clear     = 1'b1;
          end else begin
            fifo_rd_en = !fifo_empty && (occ < OCC_W'(SKID_DEPTH));
            push       = fifo_rd_en;
          end
        end
        ST_FLUSH: begin
          fifo_rd_en = !fifo_empty;
          if (fifo_empty) begin
            state_nxt = ST_RUN;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      rd_count   <= '0;
    end else begin
      flush_busy <= (state_nxt == ST_FLUSH);
      flush_done <= done_nxt;
      if (pop) rd_count <= rd_count + CW'(1);
    end
  end

  sm_skid_buf2 #(
    .DW (DW)
  ) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (fifo_data),
    .occ   (occ),
    .valid (m_valid),
    .head  (m_data)
  );

endmodule

// File: tb/tb_sm_fifo_rd_stream.sv
// Scoreboard bench for sm_fifo_rd_stream with a behavioural show-ahead FIFO model.
module tb_sm_fifo_rd_stream;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          flush = 1'b0;
  logic          flush_busy;
  logic          flush_done;
  logic [15:0]   rd_count;

  logic          rd_en4;
  logic          m_valid4;
  logic [DW-1:0] m_data4;
  logic          flush_busy4;
  logic          flush_done4;
  logic [3:0]    rd_count4;

  logic [DW-1:0] mem [64];
  logic [5:0]    wp = '0;
  logic [5:0]    rp = '0;
  logic          model_clr = 1'b0;

  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  assign fifo_data  = mem[rp];

  always @(posedge clk) begin
    if (model_clr)       rp <= wp;
    else if (fifo_rd_en) rp <= rp + 6'd1;
  end

  sm_fifo_rd_stream #(.DW(DW), .CW(16)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done), .rd_count(rd_count)
  );

  sm_fifo_rd_stream #(.DW(DW), .CW(4)) dut4 (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_en4), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .flush(flush), .flush_busy(flush_busy4), .flush_done(flush_done4), .rd_count(rd_count4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fifo_write(input logic [DW-1:0] w, input bit delivered);
    mem[wp] = w;
    wp = wp + 6'd1;
    if (delivered) exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_ready = 1'b0;
    flush = 1'b0;
    model_clr = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_clr = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_budget", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: scoreboard on every handshake plus the per-cycle safety check.
  always @(negedge clk) begin
    if (rstn) begin
      check("no_pop_when_empty", 64'(fifo_rd_en && fifo_empty), 64'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(m_data), 64'hDEAD_0000);
        end else begin
          check("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rp0;
    int         n;

    // Reset state
    do_reset();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_flush_busy", 64'(flush_busy), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);

    // Streaming at full rate: 0x11..0x18
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_write(DW'(32'h11 + i), 1'b1);
    @(posedge clk); #1;
    check("t1_first_valid", 64'(m_valid), 64'd1);
    check("t1_first_data", 64'(m_data), 64'h11);
    repeat (8) begin @(posedge clk); #1; end
    check("t1_rd_count", 64'(rd_count), 64'd8);
    check("t1_all_seen", 64'(exp_q.size()), 64'd0);
    check("t1_idle_valid", 64'(m_valid), 64'd0);

    // Backpressure: 4 words, stalled 10 cycles
    do_reset();
    rp0 = rp;
    for (int i = 0; i < 4; i++) fifo_write(DW'(32'hC0 + i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t2_hold_data", 64'(m_data), 64'hC0);
    end
    check("t2_two_pops", 64'(6'(rp - rp0)), 64'd2);
    check("t2_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    wait_drain(20);
    check("t2_rd_count", 64'(rd_count), 64'd4);

    // Toggling ready over 0xA0..0xAF
    do_reset();
    for (int i = 0; i < 16; i++) fifo_write(DW'(32'hA0 + i), 1'b1);
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      m_ready = !m_ready;
      n++;
    end
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    check("t3_rd_count", 64'(rd_count), 64'd16);

    // Flush with full buffer and 3 words left in the FIFO
    do_reset();
    rp0 = rp;
    fifo_write(DW'(32'hB0), 1'b1);
    for (int i = 1; i < 5; i++) fifo_write(DW'(32'hB0 + i), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_preflush_pops", 64'(6'(rp - rp0)), 64'd2);
    flush = 1'b1;
    m_ready = 1'b1;
    #1;
    check("t4_no_pop_on_entry", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("t4_busy", 64'(flush_busy), 64'd1);
    check("t4_valid_in_flush", 64'(m_valid), 64'd0);
    check("t4_head_counted", 64'(rd_count), 64'd1);
    rp0 = rp;
    n = 0;
    while (!flush_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_flush_cycles", 64'(n), 64'd4);
    check("t4_discarded", 64'(6'(rp - rp0)), 64'd3);
    check("t4_busy_clr", 64'(flush_busy), 64'd0);
    check("t4_valid_after", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    check("t4_done_pulse", 64'(flush_done), 64'd0);
    check("t4_rd_count_hold", 64'(rd_count), 64'd1);

    // Flush with everything empty
    do_reset();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t5_busy", 64'(flush_busy), 64'd1);
    check("t5_not_done", 64'(flush_done), 64'd0);
    @(posedge clk); #1;
    check("t5_busy_clr", 64'(flush_busy), 64'd0);
    check("t5_done", 64'(flush_done), 64'd1);
    check("t5_rd_count", 64'(rd_count), 64'd0);
    @(posedge clk); #1;
    check("t5_done_pulse", 64'(flush_done), 64'd0);

    // Reset mid-flush while a writer keeps the FIFO non-empty
    do_reset();
    flush = 1'b1;
    fifo_write(DW'(32'hE0), 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("t6_busy", 64'(flush_busy), 64'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      fifo_write(DW'(32'hE0 + i), 1'b0);
    end
    check("t6_still_busy", 64'(flush_busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("t6_rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1;
    check("t6_busy_rst", 64'(flush_busy), 64'd0);
    check("t6_done_rst", 64'(flush_done), 64'd0);
    check("t6_valid_rst", 64'(m_valid), 64'd0);
    check("t6_data_rst", 64'(m_data), 64'd0);
    check("t6_count_rst", 64'(rd_count), 64'd0);
    do_reset();
    @(posedge clk); #1;
    check("t6_no_done", 64'(flush_done), 64'd0);

    // Reset mid-stream
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(DW'(32'hF0 + i), 1'b1);
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_partial", 64'(rd_count), 64'd2);
    rstn = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    #1;
    check("t7_rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1;
    check("t7_valid_rst", 64'(m_valid), 64'd0);
    check("t7_data_rst", 64'(m_data), 64'd0);
    check("t7_count_rst", 64'(rd_count), 64'd0);
    check("t7_busy_rst", 64'(flush_busy), 64'd0);

    // Counter wrap: 17 deliveries
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) fifo_write(DW'(32'hD0 + i), 1'b1);
    wait_drain(40);
    check("t8_count16", 64'(rd_count), 64'd17);
    check("t8_count4_wrap", 64'(rd_count4), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
